// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing stage:
// opcodes, FSM state encoding and instruction field positions.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 3;
    localparam int RS_MSB = 2;
    localparam int RS_LSB = 1;
    localparam int WBEN   = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DEC  = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction channel: valid/ready handshake carrying an 8-bit instruction.
// master offers instructions, slave (the sequencer) accepts them.
interface alu_exec_ctrl_if;

    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready
    );

endinterface

// File: rtl/regfile_4x8.sv
// Register file with two asynchronous read ports and one synchronous
// write port; reset clears every entry.
module regfile_4x8 #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr_a,
    input  logic [1:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NREGS];

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

    // Write port; reset wins over any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequencer in front of the 8-bit ALU: accept, read operands, execute,
// capture result/flags, write back. One instruction every four cycles.
import alu_pkg::*;

module alu_exec_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_exec_ctrl_if.slave    instr_if,
    input  logic              ld_valid,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_Ain,
    output logic [DATA_W-1:0] alu_Bin,
    output logic              alu_Carryin,
    output logic [2:0]        alu_op_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_Carryout,
    output logic [DATA_W-1:0] result,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              done,
    output logic              busy
);

    state_t state, state_n;

    logic [7:0]        instr_q;
    logic [1:0]        rd, rs;
    logic              wb_en;
    logic              rf_we;
    logic [1:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              accept;

    assign rd    = instr_q[RD_MSB:RD_LSB];
    assign rs    = instr_q[RS_MSB:RS_LSB];
    assign wb_en = instr_q[WBEN];

    regfile_4x8 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rd),
        .raddr_b (rs),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state, handshake and the shared RF write-port mux.
    always_comb begin
        state_n              = state;
        instr_if.instr_ready = 1'b0;
        accept               = 1'b0;
        rf_we                = 1'b0;
        rf_waddr             = ld_addr;
        rf_wdata             = ld_data;
        done                 = 1'b0;
        busy                 = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy                 = 1'b0;
                instr_if.instr_ready = ~ld_valid;
                if (ld_valid) begin
                    rf_we = 1'b1;
                end else if (instr_if.instr_valid) begin
                    accept  = 1'b1;
                    state_n = S_DEC;
                end
            end
            S_DEC:  state_n = S_EXEC;
            S_EXEC: state_n = S_WB;
            S_WB: begin
                done     = 1'b1;
                rf_we    = wb_en;
                rf_waddr = rd;
                rf_wdata = result;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath registers: instruction latch, ALU inputs, result and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= '0;
            alu_Ain     <= '0;
            alu_Bin     <= '0;
            alu_Carryin <= 1'b0;
            alu_op_sel  <= OP_ADD;
            result      <= '0;
            carry_flag  <= 1'b0;
            zero_flag   <= 1'b0;
        end else begin
            if (accept) instr_q <= instr_if.instr;
            if (state == S_DEC) begin
                alu_Ain     <= rf_a;
                alu_Bin     <= rf_b;
                alu_op_sel  <= instr_q[OP_MSB:OP_LSB];
                alu_Carryin <= carry_flag;
            end
            if (state == S_EXEC) begin
                result     <= alu_out;
                carry_flag <= alu_Carryout;
                zero_flag  <= (alu_out == '0);
            end
        end
    end

endmodule
